// File: rtl/udp_packet_transmitter_pkg.sv
// Shared constants and types for the UDP packet transmitter.
//   - Ethernet / IPv4 / UDP header field constants
//   - LocalLink flag encodings (wr_flags_o: [0] SOF, [1] EOF, [3:2] last-word byte count)
//   - Header length and checksum term count
//   - Transmit FSM state encoding
//   - One's-complement fold helper for the IPv4 header checksum
package udp_packet_transmitter_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;

    localparam logic [3:0]  LL_NONE = 4'b0000;
    localparam logic [3:0]  LL_SOF  = 4'b0001;
    localparam logic [3:0]  LL_EOF  = 4'b0010;

    localparam int          HDR_WORDS  = 11;
    localparam int          CSUM_TERMS = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CSUM    = 2'd1,
        ST_HDR     = 2'd2,
        ST_PAYLOAD = 2'd3
    } tx_state_t;

    // Ten 16-bit terms sum to at most 0x9FFF6, so two end-around-carry
    // folds always land in 16 bits. Returns the complemented checksum.
    function automatic logic [15:0] fold_csum(input logic [19:0] s);
        logic [16:0] f1;
        logic [16:0] f2;
        f1 = {1'b0, s[15:0]} + {13'b0, s[19:16]};
        f2 = {1'b0, f1[15:0]} + {16'b0, f1[16]};
        return ~f2[15:0];
    endfunction

endpackage

// File: rtl/udp_packet_transmitter_ip_header_checksum.sv
// ip_header_checksum: sequential IPv4 header checksum.
// A start pulse clears the accumulator; the next 10 cycles add one header
// halfword each into a 20-bit accumulator, and one further cycle folds and
// complements the sum. done rises with csum valid and holds until the next
// start.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start           begin a new sum (single-cycle pulse)
//   ip_len, ident   IPv4 total length and identification fields
//   ttl             IPv4 time-to-live
//   src_ip, dst_ip  IPv4 addresses (must be stable while summing)
//   csum            complemented one's-complement checksum
//   done            csum valid
module ip_header_checksum
    import udp_packet_transmitter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] ip_len,
    input  logic [15:0] ident,
    input  logic [7:0]  ttl,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    output logic [15:0] csum,
    output logic        done
);

    localparam logic [3:0] LAST_TERM = 4'(CSUM_TERMS);

    logic [19:0] acc;
    logic [3:0]  term_idx;
    logic        running;
    logic [15:0] term;

    // Halfword order follows the IPv4 header; the checksum field itself is zero.
    always_comb begin
        term = 16'h0000;
        case (term_idx)
            4'd0:    term = {IP_VER_IHL, 8'h00};
            4'd1:    term = ip_len;
            4'd2:    term = ident;
            4'd3:    term = IP_FLAGS_DF;
            4'd4:    term = {ttl, IP_PROTO_UDP};
            4'd5:    term = 16'h0000;
            4'd6:    term = src_ip[31:16];
            4'd7:    term = src_ip[15:0];
            4'd8:    term = dst_ip[31:16];
            4'd9:    term = dst_ip[15:0];
            default: term = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            term_idx <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            csum     <= '0;
        end else if (start) begin
            acc      <= '0;
            term_idx <= '0;
            running  <= 1'b1;
            done     <= 1'b0;
        end else if (running) begin
            if (term_idx == LAST_TERM) begin
                csum    <= fold_csum(acc);
                done    <= 1'b1;
                running <= 1'b0;
            end else begin
                acc      <= acc + {4'b0, term};
                term_idx <= term_idx + 4'd1;
            end
        end
    end

endmodule

// File: rtl/udp_packet_transmitter.sv
// udp_packet_transmitter: builds one Ethernet/IPv4/UDP frame per start from a
// first-word-fall-through payload FIFO and drives it into a LocalLink TX port.
// Frame: 11 header words (the last carries the UDP checksum 0000 and the
// 16-bit packet counter), then PAYLOAD_WORDS payload words, EOF on the last.
//
// Handshake: a word moves when wr_src_rdy_o & wr_dst_rdy_i are both high at
// a rising clk edge; while wr_dst_rdy_i is low, wr_data_o/wr_flags_o and the
// FSM hold and the FIFO is not popped.
//
// Optional feature: define TX_FRAME_COUNT_EN to add output frames_sent[31:0],
// a wrapping count of EOF transfers.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   enable                   allow a new packet (sampled in IDLE only)
//   data_in, data_avail      FIFO head word, FIFO holds a full packet
//   data_rd_o                FIFO pop
//   wr_data_o, wr_flags_o    LocalLink data and flags ([0] SOF, [1] EOF)
//   wr_src_rdy_o             LocalLink source ready
//   wr_dst_rdy_i             LocalLink destination ready
//   my_mac, dst_mac          source / destination MAC
//   my_ip, dst_ip            source / destination IPv4 address
//   src_port, dst_port       UDP ports
//   busy                     high outside IDLE
//   frames_sent              (TX_FRAME_COUNT_EN) EOF transfer count
//   state_dbg                current FSM state
module udp_packet_transmitter
    import udp_packet_transmitter_pkg::*;
#(
    parameter int         PAYLOAD_WORDS = 64,
    parameter logic [7:0] TTL           = 8'h40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] data_in,
    input  logic        data_avail,
    output logic        data_rd_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  wr_flags_o,
    output logic        wr_src_rdy_o,
    input  logic        wr_dst_rdy_i,
    input  logic [47:0] my_mac,
    input  logic [47:0] dst_mac,
    input  logic [31:0] my_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    output logic        busy,
`ifdef TX_FRAME_COUNT_EN
    output logic [31:0] frames_sent,
`endif
    output logic [1:0]  state_dbg
);

    localparam logic [15:0] IP_LEN   = 16'(30 + 4 * PAYLOAD_WORDS);
    localparam logic [15:0] UDP_LEN  = 16'(10 + 4 * PAYLOAD_WORDS);
    localparam logic [3:0]  HDR_LAST = 4'(HDR_WORDS - 1);
    localparam logic [8:0]  PAY_LAST = 9'(PAYLOAD_WORDS - 1);

    tx_state_t   state, state_next;
    logic [3:0]  hdr_idx;
    logic [8:0]  pay_idx;
    logic [15:0] pkt_counter;
    logic [31:0] hdr_word;

    logic [47:0] lat_dst_mac, lat_my_mac;
    logic [31:0] lat_dst_ip, lat_my_ip;
    logic [15:0] lat_src_port, lat_dst_port;

    logic [15:0] ip_csum;
    logic        csum_done;

    logic start_pkt;
    logic xfer;
    logic eof_xfer;

    assign start_pkt = (state == ST_IDLE) && enable && data_avail;
    assign xfer      = wr_src_rdy_o && wr_dst_rdy_i;
    assign eof_xfer  = (state == ST_PAYLOAD) && xfer && (pay_idx == PAY_LAST);
    assign state_dbg = state;

    ip_header_checksum u_csum (
        .clk    (clk),
        .reset  (reset),
        .start  (start_pkt),
        .ip_len (IP_LEN),
        .ident  (pkt_counter),
        .ttl    (TTL),
        .src_ip (lat_my_ip),
        .dst_ip (lat_dst_ip),
        .csum   (ip_csum),
        .done   (csum_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start_pkt) state_next = ST_CSUM;
            ST_CSUM:    if (csum_done) state_next = ST_HDR;
            ST_HDR:     if (xfer && hdr_idx == HDR_LAST) state_next = ST_PAYLOAD;
            ST_PAYLOAD: if (eof_xfer) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Output logic; payload words flow straight from the FIFO head.
    always_comb begin
        wr_data_o    = 32'h0;
        wr_flags_o   = LL_NONE;
        wr_src_rdy_o = 1'b0;
        data_rd_o    = 1'b0;
        busy         = (state != ST_IDLE);
        case (state)
            ST_HDR: begin
                wr_src_rdy_o = 1'b1;
                wr_data_o    = hdr_word;
                wr_flags_o   = (hdr_idx == 4'd0) ? LL_SOF : LL_NONE;
            end
            ST_PAYLOAD: begin
                wr_src_rdy_o = 1'b1;
                wr_data_o    = data_in;
                data_rd_o    = wr_dst_rdy_i;
                wr_flags_o   = (pay_idx == PAY_LAST) ? LL_EOF : LL_NONE;
            end
            default: ;
        endcase
    end

    always_comb begin
        hdr_word = 32'h0;
        case (hdr_idx)
            4'd0:    hdr_word = lat_dst_mac[47:16];
            4'd1:    hdr_word = {lat_dst_mac[15:0], lat_my_mac[47:32]};
            4'd2:    hdr_word = lat_my_mac[31:0];
            4'd3:    hdr_word = {ETHERTYPE_IPV4, IP_VER_IHL, 8'h00};
            4'd4:    hdr_word = {IP_LEN, pkt_counter};
            4'd5:    hdr_word = {IP_FLAGS_DF, TTL, IP_PROTO_UDP};
            4'd6:    hdr_word = {ip_csum, lat_my_ip[31:16]};
            4'd7:    hdr_word = {lat_my_ip[15:0], lat_dst_ip[31:16]};
            4'd8:    hdr_word = {lat_dst_ip[15:0], lat_src_port};
            4'd9:    hdr_word = {lat_dst_port, UDP_LEN};
            4'd10:   hdr_word = {16'h0000, pkt_counter};
            default: hdr_word = 32'h0;
        endcase
    end

    // Word indices and the per-packet snapshot of the addressing inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_idx      <= '0;
            pay_idx      <= '0;
            lat_dst_mac  <= '0;
            lat_my_mac   <= '0;
            lat_dst_ip   <= '0;
            lat_my_ip    <= '0;
            lat_src_port <= '0;
            lat_dst_port <= '0;
        end else begin
            if (start_pkt) begin
                hdr_idx      <= '0;
                pay_idx      <= '0;
                lat_dst_mac  <= dst_mac;
                lat_my_mac   <= my_mac;
                lat_dst_ip   <= dst_ip;
                lat_my_ip    <= my_ip;
                lat_src_port <= src_port;
                lat_dst_port <= dst_port;
            end
            if (state == ST_HDR && xfer)     hdr_idx <= hdr_idx + 4'd1;
            if (state == ST_PAYLOAD && xfer) pay_idx <= pay_idx + 9'd1;
        end
    end

    // Packet counter only changes on reset or a completed frame.
    always_ff @(posedge clk) begin
        if (reset)         pkt_counter <= '0;
        else if (eof_xfer) pkt_counter <= pkt_counter + 16'd1;
    end

`ifdef TX_FRAME_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)         frames_sent <= '0;
        else if (eof_xfer) frames_sent <= frames_sent + 32'd1;
    end
`endif

endmodule

// File: tb/tb_udp_packet_transmitter.sv
module tb_udp_packet_transmitter;

  localparam int PW = 4;
  localparam int FRAME_WORDS = 11 + PW;
  localparam logic [15:0] E_IP_LEN = 16'd46;
  localparam logic [15:0] E_UDP_LEN = 16'd26;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic [31:0] data_in;
  logic data_avail;
  logic data_rd_o;
  logic [31:0] wr_data_o;
  logic [3:0] wr_flags_o;
  logic wr_src_rdy_o;
  logic wr_dst_rdy_i;
  logic [47:0] my_mac, dst_mac;
  logic [31:0] my_ip, dst_ip;
  logic [15:0] src_port, dst_port;
  logic busy;
  logic [1:0] state_dbg;
`ifdef TX_FRAME_COUNT_EN
  logic [31:0] frames_sent;
  int exp_frames = 0;
`endif

  int checks = 0;
  int errors = 0;

  logic [35:0] exp_q[$];
  logic [35:0] got_q[$];

  logic [31:0] fifo_mem[0:7];
  int pop_count = 0;
  int fifo_base = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  udp_packet_transmitter #(.PAYLOAD_WORDS(PW), .TTL(8'h40)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .data_in(data_in),
    .data_avail(data_avail),
    .data_rd_o(data_rd_o),
    .wr_data_o(wr_data_o),
    .wr_flags_o(wr_flags_o),
    .wr_src_rdy_o(wr_src_rdy_o),
    .wr_dst_rdy_i(wr_dst_rdy_i),
    .my_mac(my_mac),
    .dst_mac(dst_mac),
    .my_ip(my_ip),
    .dst_ip(dst_ip),
    .src_port(src_port),
    .dst_port(dst_port),
    .busy(busy),
`ifdef TX_FRAME_COUNT_EN
    .frames_sent(frames_sent),
`endif
    .state_dbg(state_dbg)
  );

  // FWFT FIFO model: head is the next unread entry.
  assign data_in = fifo_mem[3'(pop_count - fifo_base)];

  always @(posedge clk) begin
    if (data_rd_o) pop_count = pop_count + 1;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_csum(input logic [15:0] ident);
    logic [31:0] s;
    s = 32'h4500 + {16'h0, E_IP_LEN} + {16'h0, ident} + 32'h4000 + 32'h4011
        + {16'h0, my_ip[31:16]} + {16'h0, my_ip[15:0]}
        + {16'h0, dst_ip[31:16]} + {16'h0, dst_ip[15:0]};
    while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    return ~s[15:0];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_fifo(input logic [31:0] base);
    for (int i = 0; i < 8; i++) fifo_mem[i] = (i < PW) ? base + 32'(i) : 32'h0;
    fifo_base = pop_count;
  endtask

  task automatic push_expected(input logic [15:0] cnt, input int n);
    logic [31:0] w[0:FRAME_WORDS-1];
    logic [3:0] f;
    w[0]  = dst_mac[47:16];
    w[1]  = {dst_mac[15:0], my_mac[47:32]};
    w[2]  = my_mac[31:0];
    w[3]  = 32'h0800_4500;
    w[4]  = {E_IP_LEN, cnt};
    w[5]  = 32'h4000_4011;
    w[6]  = {model_csum(cnt), my_ip[31:16]};
    w[7]  = {my_ip[15:0], dst_ip[31:16]};
    w[8]  = {dst_ip[15:0], src_port};
    w[9]  = {dst_port, E_UDP_LEN};
    w[10] = {16'h0000, cnt};
    for (int i = 0; i < PW; i++) w[11+i] = fifo_mem[i];
    for (int i = 0; i < n; i++) begin
      f = (i == 0) ? 4'b0001 : (i == FRAME_WORDS - 1) ? 4'b0010 : 4'b0000;
      exp_q.push_back({f, w[i]});
    end
  endtask

  // Start one packet and collect transferred words into got_q.
  // abort_at >= 0 stops collecting once that many words were presented/accepted.
  task automatic run_frame(input int stall_pct, input int abort_at, input bit perturb);
    int lat;
    int idx;
    bit done;
    bit rdy;
    bit stalled;
    logic [31:0] prev_data;
    logic [3:0] prev_flags;
    logic [31:0] save_ip;
    logic [15:0] save_port;
    save_ip = my_ip;
    save_port = dst_port;
    @(negedge clk);
    enable = 1'b1;
    data_avail = 1'b1;
    wr_dst_rdy_i = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b0;
    check("busy_after_start", busy, 1);
    if (perturb) begin
      my_ip = 32'h0A00_0001;
      dst_port = 16'hDEAD;
    end
    lat = 0;
    while (!wr_src_rdy_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("sof_latency", 64'(lat), 64'd12);
    idx = 0;
    done = 0;
    stalled = 0;
    prev_data = '0;
    prev_flags = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      rdy = ($urandom_range(0, 99) < stall_pct) ? 1'b0 : 1'b1;
      wr_dst_rdy_i = rdy;
      #1;
      check("src_rdy_in_frame", wr_src_rdy_o, 1);
      if (stalled) begin
        check("stall_data", wr_data_o, prev_data);
        check("stall_flags", wr_flags_o, prev_flags);
      end
      check("fifo_pop", data_rd_o, (rdy && idx >= 11));
      if (rdy) begin
        got_q.push_back({wr_flags_o, wr_data_o});
        idx++;
        if (wr_flags_o[1] || idx == abort_at || idx > FRAME_WORDS) done = 1;
      end
      stalled = !rdy;
      prev_data = wr_data_o;
      prev_flags = wr_flags_o;
    end
    if (!done) check("frame_timeout", 0, 1);
    if (abort_at < 0) begin
      @(negedge clk);
      wr_dst_rdy_i = 1'b0;
      #1;
      check("idle_src_rdy", wr_src_rdy_o, 0);
      check("idle_busy", busy, 0);
`ifdef TX_FRAME_COUNT_EN
      exp_frames++;
      check("frames_sent", frames_sent, 64'(exp_frames));
`endif
    end
    if (perturb) begin
      my_ip = save_ip;
      dst_port = save_port;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic compare_frame(input string tag);
    logic [35:0] g;
    logic [35:0] e;
    check({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check(tag, g, e);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [35:0] g;
    reset = 1'b1;
    enable = 1'b0;
    data_avail = 1'b0;
    wr_dst_rdy_i = 1'b0;
    my_mac = 48'h000A_3501_0203;
    dst_mac = 48'h0011_2233_4455;
    my_ip = 32'hC0A8_010A;
    dst_ip = 32'hC0A8_0101;
    src_port = 16'h1234;
    dst_port = 16'h5678;
    load_fifo(32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_src_rdy", wr_src_rdy_o, 0);
    check("rst_busy", busy, 0);
    check("rst_data", wr_data_o, 0);
    check("rst_flags", wr_flags_o, 0);
    check("rst_rd", data_rd_o, 0);
`ifdef TX_FRAME_COUNT_EN
    check("rst_frames", frames_sent, 0);
`endif
    reset = 1'b0;

    // Frame 1: hand-computed header fields, no stalls, counter 0.
    load_fifo(32'h1);
    push_expected(16'h0000, FRAME_WORDS);
    run_frame(0, -1, 0);
    check("s1_words", 64'(got_q.size()), 64'd15);
    if (got_q.size() == 15) begin
      g = got_q[4];
      check("s1_w4", g[31:0], 32'h002E_0000);
      g = got_q[9];
      check("s1_w9", g[31:0], 32'h5678_001A);
      g = got_q[6];
      check("s1_csum", g[31:16], 16'hB763);
      g = got_q[0];
      check("s1_sof", g[35:32], 4'b0001);
      g = got_q[14];
      check("s1_eof", g[35:32], 4'b0010);
      check("s1_last_pay", g[31:0], 32'h4);
      g = got_q[11];
      check("s1_first_pay", g[31:0], 32'h1);
    end
    compare_frame("s1");
    check("s1_pops", 64'(pop_count - fifo_base), 64'd4);

    // Frame 2: counter advances to 1.
    load_fifo(32'h1);
    push_expected(16'h0001, FRAME_WORDS);
    run_frame(0, -1, 0);
    compare_frame("s2");
    check("s2_pops", 64'(pop_count - fifo_base), 64'd4);

    // Frame 3: random stalls, inputs changed after start must be ignored.
    load_fifo(32'h1);
    push_expected(16'h0002, FRAME_WORDS);
    run_frame(40, -1, 1);
    compare_frame("s3");
    check("s3_pops", 64'(pop_count - fifo_base), 64'd4);

    // Counter wrap: FFFF then 0000.
    @(negedge clk);
    force dut.pkt_counter = 16'hFFFF;
    #1;
    release dut.pkt_counter;
    load_fifo(32'hA000_0000);
    push_expected(16'hFFFF, FRAME_WORDS);
    run_frame(20, -1, 0);
    compare_frame("s4a");
    load_fifo(32'hA000_0010);
    push_expected(16'h0000, FRAME_WORDS);
    run_frame(0, -1, 0);
    compare_frame("s4b");

    // Reset while payload word 2 is presented.
    load_fifo(32'h5000_0000);
    push_expected(16'h0001, 13);
    run_frame(0, 13, 0);
    compare_frame("s5_partial");
    @(negedge clk);
    reset = 1'b1;
    wr_dst_rdy_i = 1'b0;
    @(posedge clk);
    #1;
    check("s5_src_rdy", wr_src_rdy_o, 0);
    check("s5_busy", busy, 0);
    check("s5_data", wr_data_o, 0);
    check("s5_flags", wr_flags_o, 0);
`ifdef TX_FRAME_COUNT_EN
    check("s5_frames", frames_sent, 0);
    exp_frames = 0;
`endif
    @(negedge clk);
    reset = 1'b0;
    load_fifo(32'h6000_0000);
    push_expected(16'h0000, FRAME_WORDS);
    run_frame(0, -1, 0);
    compare_frame("s5_after");

    // No start without both enable and data_avail.
    @(negedge clk);
    enable = 1'b0;
    data_avail = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("s6_noen_src_rdy", wr_src_rdy_o, 0);
      check("s6_noen_busy", busy, 0);
    end
    enable = 1'b1;
    data_avail = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("s6_noavail_src_rdy", wr_src_rdy_o, 0);
      check("s6_noavail_busy", busy, 0);
    end
    enable = 1'b0;
    data_avail = 1'b1;
`ifdef TX_FRAME_COUNT_EN
    check("s6_frames", frames_sent, 64'(exp_frames));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
